// File: rtl/pio_in_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register map,
// edge-type selectors and interrupt-mode selectors.
package pio_pkg;

    // Avalon word addresses of the register file
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // EDGE_TYPE parameter encodings
    localparam int EDGE_RISE = 32'sd0;
    localparam int EDGE_FALL = 32'sd1;
    localparam int EDGE_ANY  = 32'sd2;

    // IRQ_MODE parameter encodings
    localparam int IRQ_NONE  = 32'sd0;
    localparam int IRQ_LEVEL = 32'sd1;
    localparam int IRQ_EDGE  = 32'sd2;

endpackage

// File: rtl/pio_in_edge_irq_sync_debounce.sv
// Single-bit input conditioner: a SYNC_STAGES flop synchroniser followed
// by an optional stability counter. With DEBOUNCE_CYCLES = 0 the output is
// the synchroniser output directly.
module pio_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic deb_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    // Synchroniser shift chain; the oldest stage is the synchronised value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb_o = sync_s;
    end else begin : g_debounce
        localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0]  CNT_ONE = CW'(1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          last_q;
        logic          deb_q;
        logic          deb_d;

        // Count consecutive equal samples; commit the value once the run is long enough
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (sync_s != last_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_d == CNT_MAX) begin
                deb_d = sync_s;
            end else begin
                deb_d = deb_q;
            end
        end

        // Debounce state registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                last_q <= 1'b0;
                deb_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                last_q <= sync_s;
                deb_q  <= deb_d;
            end
        end

        assign deb_o = deb_q;
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit synchroniser/debouncer, edge capture
// (write-1-to-clear, set wins over clear), interrupt mask and irq output.
// Edge detection is held off after reset until the input pipeline has
// filled, so inputs already high at reset do not register as edges.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int              ACW        = $clog2(ARM_CYCLES);
    localparam logic [ACW-1:0]  ARM_LAST   = ACW'(ARM_CYCLES - 1);
    localparam logic [ACW-1:0]  ARM_ONE    = ACW'(1);

    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] sel_s;
    logic [WIDTH-1:0] det_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;
    logic             irq_s;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] ecap_q,    ecap_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic [ACW-1:0]   arm_cnt_q, arm_cnt_d;
    logic             armed_q,   armed_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_sync_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sd (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[g]),
            .deb_o  (deb_s[g])
        );
    end

    if (WIDTH < 32) begin : g_wd_hi
        logic unused_wd_hi_s;
        assign unused_wd_hi_s = ^writedata[31:WIDTH];
    end

    assign wr_s    = chipselect & ~write_n;
    assign wdata_s = writedata[WIDTH-1:0];
    assign rise_s  = deb_s & ~prev_q;
    assign fall_s  = ~deb_s & prev_q;

    // Select the configured edge polarity and suppress it until armed
    always_comb begin
        sel_s = '0;
        case (EDGE_TYPE)
            EDGE_RISE: sel_s = rise_s;
            EDGE_FALL: sel_s = fall_s;
            EDGE_ANY:  sel_s = rise_s | fall_s;
            default:   sel_s = '0;
        endcase
        det_s = armed_q ? sel_s : '0;
    end

    // Next state of mask, edge capture and arming counter
    always_comb begin
        mask_d    = mask_q;
        clr_s     = '0;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (wr_s && (address == ADDR_MASK)) begin
            mask_d = wdata_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            clr_s = wdata_s;
        end else begin
            clr_s = '0;
        end
        // a new detection is OR-ed in after the clear so it always survives
        ecap_d = (ecap_q & ~clr_s) | det_s;
        if (arm_cnt_q == ARM_LAST) begin
            arm_cnt_d = arm_cnt_q;
            armed_d   = 1'b1;
        end else begin
            arm_cnt_d = arm_cnt_q + ARM_ONE;
            armed_d   = armed_q;
        end
    end

    // Read mux, reloaded every cycle regardless of chipselect
    always_comb begin
        rdata_d = 32'h0000_0000;
        case (address)
            ADDR_DATA: rdata_d[WIDTH-1:0] = deb_s;
            ADDR_RSVD: rdata_d = 32'h0000_0000;
            ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rdata_d[WIDTH-1:0] = ecap_q;
            default:   rdata_d = 32'h0000_0000;
        endcase
    end

    // Interrupt from registered state only
    always_comb begin
        irq_s = 1'b0;
        case (IRQ_MODE)
            IRQ_NONE:  irq_s = 1'b0;
            IRQ_LEVEL: irq_s = |(deb_s & mask_q);
            IRQ_EDGE:  irq_s = |(ecap_q & mask_q);
            default:   irq_s = 1'b0;
        endcase
    end

    // Register file, edge history and arming state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            mask_q    <= '0;
            ecap_q    <= '0;
            rdata_q   <= 32'h0000_0000;
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            prev_q    <= deb_s;
            mask_q    <= mask_d;
            ecap_q    <= ecap_d;
            rdata_q   <= rdata_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_s;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four configurations share one bus; a
// behavioural model (delay-line queue, run-length debounce, counted arming)
// predicts readdata and irq every cycle, plus directed constant checks.
module tb_pio_in_edge_irq;

    localparam int P_S [4] = '{2, 2, 3, 4};
    localparam int P_D [4] = '{0, 4, 0, 2};
    localparam int P_E [4] = '{0, 0, 1, 2};
    localparam int P_M [4] = '{2, 2, 1, 0};

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_p  [4];
    logic [31:0] rd    [4];
    logic        irq_w [4];

    int checks   = 0;
    int failures = 0;

    // model state
    logic [7:0]  m_hist [4][$];
    logic [7:0]  m_deb  [4];
    logic [7:0]  m_prev [4];
    logic [7:0]  m_mask [4];
    logic [7:0]  m_ecap [4];
    logic [31:0] m_rd   [4];
    logic [7:0]  m_runv [4];
    int          m_run  [4][8];
    int          m_n;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pio_in_edge_irq #(
            .WIDTH          (8),
            .SYNC_STAGES    (P_S[g]),
            .DEBOUNCE_CYCLES(P_D[g]),
            .EDGE_TYPE      (P_E[g]),
            .IRQ_MODE       (P_M[g])
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_p[g]),
            .readdata  (rd[g]),
            .irq       (irq_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i].delete();
            repeat (6) m_hist[i].push_back(8'h00);
            m_deb[i] = 8'h00; m_prev[i] = 8'h00; m_mask[i] = 8'h00;
            m_ecap[i] = 8'h00; m_rd[i] = 32'h0; m_runv[i] = 8'h00;
            for (int b = 0; b < 8; b++) m_run[i][b] = 1;
        end
        m_n = 0;
    endtask

    function automatic logic exp_irq(int i);
        if (P_M[i] == 1) return |(m_deb[i] & m_mask[i]);
        if (P_M[i] == 2) return |(m_ecap[i] & m_mask[i]);
        return 1'b0;
    endfunction

    // one rising clock edge of the reference behaviour
    task automatic model_edge();
        logic       wr, armed;
        logic [7:0] wd, rise, fall, det, clr, s_after, s_before;
        wr = chipselect && !write_n;
        wd = writedata[7:0];
        for (int i = 0; i < 4; i++) begin
            armed = (m_n >= P_S[i] + P_D[i] + 1);
            rise  = m_deb[i] & ~m_prev[i];
            fall  = ~m_deb[i] & m_prev[i];
            det   = (P_E[i] == 0) ? rise : (P_E[i] == 1) ? fall : (rise | fall);
            if (!armed) det = 8'h00;
            case (address)
                2'd0:    m_rd[i] = {24'h0, m_deb[i]};
                2'd2:    m_rd[i] = {24'h0, m_mask[i]};
                2'd3:    m_rd[i] = {24'h0, m_ecap[i]};
                default: m_rd[i] = 32'h0;
            endcase
            clr = (wr && address == 2'd3) ? wd : 8'h00;
            m_ecap[i] = (m_ecap[i] & ~clr) | det;
            if (wr && address == 2'd2) m_mask[i] = wd;
            m_prev[i] = m_deb[i];
            m_hist[i].push_front(in_p[i]);
            void'(m_hist[i].pop_back());
            s_after  = m_hist[i][P_S[i] - 1];
            s_before = m_hist[i][P_S[i]];
            if (P_D[i] == 0) begin
                m_deb[i] = s_after;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (s_before[b] == m_runv[i][b]) m_run[i][b]++;
                    else begin m_runv[i][b] = s_before[b]; m_run[i][b] = 1; end
                    if (m_run[i][b] - 1 >= P_D[i]) m_deb[i][b] = s_before[b];
                end
            end
        end
        m_n++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_rd%0d", i), rd[i], m_rd[i]);
            chk($sformatf("model_irq%0d", i), {31'h0, irq_w[i]}, {31'h0, exp_irq(i)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        logic saw;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
        in_p[0] = 8'hFF; in_p[1] = 8'h00; in_p[2] = 8'h00; in_p[3] = 8'h00;
        model_reset();
        #1;
        check_all();
        chk("reset_rd0", rd[0], 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // inputs high through reset: no edge after arming
        bus_write(2'd2, 32'hFF);
        address = 2'd3;
        repeat (10) tick();
        chk("armed_ecap0", rd[0], 32'h0);
        chk("armed_irq0", {31'h0, irq_w[0]}, 32'h0);
        address = 2'd0;
        tick();
        chk("data_rd0", rd[0], 32'h0000_00FF);

        // rising capture, latency SYNC_STAGES+1
        in_p[0] = 8'h00;
        repeat (6) tick();
        address = 2'd3;
        in_p[0] = 8'h05;
        tick(); tick();
        chk("rise_irq_early", {31'h0, irq_w[0]}, 32'h0);
        tick();
        chk("rise_irq", {31'h0, irq_w[0]}, 32'h1);
        tick();
        chk("rise_ecap", rd[0], 32'h05);
        bus_write(2'd3, 32'h01);
        tick();
        chk("w1c_ecap", rd[0], 32'h04);
        chk("w1c_irq", {31'h0, irq_w[0]}, 32'h1);

        // set and clear of the same bit in one cycle
        in_p[0] = 8'h01;
        repeat (5) tick();
        bus_write(2'd3, 32'hFF);
        tick();
        in_p[0] = 8'h05;
        tick(); tick();
        bus_write(2'd3, 32'h04);
        tick();
        chk("setwins_ecap", rd[0], 32'h04);
        tick();
        chk("setwins_hold", rd[0], 32'h04);

        // debounce: short pulse filtered, long pulse captured once
        in_p[1] = 8'h01;
        repeat (3) tick();
        in_p[1] = 8'h00;
        repeat (15) tick();
        chk("glitch_ecap1", rd[1], 32'h0);
        address = 2'd0;
        tick();
        chk("glitch_data1", rd[1], 32'h0);
        saw = 1'b0;
        in_p[1] = 8'h01;
        repeat (6) begin tick(); saw |= rd[1][0]; end
        in_p[1] = 8'h00;
        repeat (15) begin tick(); saw |= rd[1][0]; end
        chk("pulse_deb1", {31'h0, saw}, 32'h1);
        address = 2'd3;
        tick();
        chk("pulse_ecap1", rd[1], 32'h01);
        bus_write(2'd3, 32'h01);
        repeat (15) tick();
        chk("pulse_once1", rd[1], 32'h0);

        // level interrupt
        bus_write(2'd2, 32'h00);
        in_p[2] = 8'h10;
        repeat (6) tick();
        chk("lvl_irq_off", {31'h0, irq_w[2]}, 32'h0);
        bus_write(2'd2, 32'h10);
        chk("lvl_irq_on", {31'h0, irq_w[2]}, 32'h1);
        address = 2'd2;
        tick();
        chk("lvl_mask_rd", rd[2], 32'h0000_0010);

        // asynchronous reset mid-operation
        bus_write(2'd2, 32'h30);
        in_p[0] = 8'h00;
        repeat (5) tick();
        bus_write(2'd3, 32'hFF);
        tick();
        in_p[0] = 8'hAA;
        repeat (5) tick();
        address = 2'd3;
        tick();
        chk("pre_rst_ecap", rd[0], 32'hAA);
        chk("pre_rst_irq", {31'h0, irq_w[0]}, 32'h1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rd0", rd[0], 32'h0);
        chk("rst_irq0", {31'h0, irq_w[0]}, 32'h0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ecap", rd[0], 32'h0);
        address = 2'd2;
        tick();
        chk("post_rst_mask", rd[0], 32'h0);
        address = 2'd3;
        repeat (10) tick();
        chk("post_arm_ecap", rd[0], 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) in_p[i] = in_p[i] ^ (8'($urandom) & 8'($urandom));
            end
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 2'($urandom);
            writedata  = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clk);
                reset_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM slave input PIO: the next generation of the single-bit read-only input port.
- Samples a WIDTH-bit external bus through a synchroniser and an optional per-bit debouncer.
- Provides an edge-capture register, an interrupt mask and an irq output.
- Sits on the system interconnect next to the existing PIO peripherals (switches, keys, card-detect/write-protect lines).

Parameters:
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 0: consecutive stable samples needed before the debounced value changes; 0 bypasses the debouncer.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- IRQ_MODE, 0: 0 = none (irq tied 0), 1 = level, 2 = edge.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active high.

Behaviour:
- Clocking and reset: one clock; reset_n is asynchronous and active-low. All flops clear on reset.
- Reset values: readdata = 0, irq = 0, edge_capture = 0, irq_mask = 0, synchroniser = 0, debounced = 0, prev = 0, armed = 0.

Input path:
- Synchroniser: SYNC_STAGES flop chain per bit. sync_out is in_port delayed SYNC_STAGES cycles.
- Debouncer, DEBOUNCE_CYCLES > 0:
  - Per-bit counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever sync_out differs from the last sample.
  - debounced[i] updates when the counter reaches DEBOUNCE_CYCLES; the counter saturates there.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches debounced.
- Debouncer, DEBOUNCE_CYCLES = 0: debounced = sync_out, with no extra latency.

Arming and edge detection:
- Arm counter: armed goes to 1 exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after reset release and stays 1.
- While armed = 0, prev tracks debounced and no edges are detected. This suppresses spurious edges from inputs that are already high at reset.
- Edge detect: prev <= debounced every cycle.
  - rise = debounced & ~prev
  - fall = ~debounced & prev
  - det is selected by EDGE_TYPE, then gated by armed.

Registers (address map):
- 0: data, RO. Read returns zero-extended debounced. Writes ignored.
- 1: reserved. Reads 0, writes ignored.
- 2: irq_mask, RW, WIDTH LSBs. Upper bits read 0.
- 3: edge_capture, RO with write-1-to-clear.
  - Write clears each bit i where writedata[i] = 1.
  - det[i] sets bit i.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.

Bus timing:
- Write occurs when chipselect = 1 and write_n = 0; it takes effect on the next clock edge.
- Read: readdata is registered and reloaded every cycle from the mux on address (no chipselect gating), giving 1 cycle of read latency, with no wait states.
- Read-after-write to the same register on the following cycle returns the new value.

Interrupt:
- irq is combinational from registered state only, with no added latency.
  - IRQ_MODE 1: irq = |(debounced & irq_mask).
  - IRQ_MODE 2: irq = |(edge_capture & irq_mask).
  - IRQ_MODE 0: irq = 0.
- Clearing the mask deasserts irq in the cycle after the write edge.

Other rules:
- Bits of writedata above WIDTH are ignored.
- Reset mid-operation clears everything immediately; arming restarts from zero.

Decomposition:
- Shared package pio_pkg:
  - Address constants ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY encodings.
  - IRQ_NONE / IRQ_LEVEL / IRQ_EDGE encodings.
- Sub-module pio_sync_debounce: a single-bit synchroniser plus debounce counter, instantiated WIDTH times via generate. The top level holds the arm counter, edge logic, register file and read mux.

Test Plan:
- Reset with in_port = 8'hFF held, EDGE_TYPE = 0, IRQ_MODE = 2, mask = 8'hFF → after arming, edge_capture = 0 and irq = 0; read addr 0 = 32'h000000FF.
- Rising-edge capture and clear:
  - Drive in_port 8'h00 → 8'h05 (DEBOUNCE_CYCLES = 0) → edge_capture = 8'h05 at cycle SYNC_STAGES + 1 after the change; irq = 1.
  - Then write 32'h01 to addr 3 → edge_capture = 8'h04 and irq stays 1.
- Simultaneous set/clear: in_port bit 2 rises in the same cycle as a write of 32'h04 to addr 3 → bit 2 remains 1.
- Debounce, DEBOUNCE_CYCLES = 4:
  - A 3-cycle pulse on bit 0 → debounced unchanged and no capture.
  - A 6-cycle pulse → debounced bit 0 = 1 and exactly one capture.
- Level mode, IRQ_MODE = 1:
  - in_port = 8'h10, mask = 0 → irq = 0.
  - Write mask 32'h10 → irq = 1 in the cycle after the write.
  - Read addr 2 returns 32'h00000010 one cycle after the read address is presented.
- Reset mid-operation: edge_capture = 8'hAA and mask nonzero, assert reset_n low asynchronously → readdata, irq, edge_capture and mask all 0 immediately; after release no captures occur until armed.
